// File: rtl/ibex_axi_rd_mux.sv
// ibex_axi_rd_mux
//   N-master to 1-slave AXI4 read-channel multiplexer (AR and R only).
//   Upstream AR requests are arbitrated round-robin. Each granted request is
//   forwarded with the master index prepended to its payload. Returning R
//   beats are routed back to the master whose index sits in the top bits of
//   m_r_pld. Each master may have at most MAX_OUTST bursts in flight.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   s_ar_*           per-master AR channels (payload {id,addr,len,size,burst})
//   s_r_*            per-master R valid/ready, payload broadcast to all
//   m_ar_*           downstream AR channel, payload {idx, upstream payload}
//   m_r_*            downstream R channel, payload {idx, id, data, resp, last}
//   err_o            sticky: R beat for an unknown index, or a burst
//                    completion for a master with no outstanding bursts
//
// Optional build macro
//   IBEX_AXI_RD_MUX_AR_REG_EN  inserts a 2-entry skid buffer in front of
//                              m_ar_*, giving 1 cycle of AR latency and no
//                              combinational m_ar_ready -> s_ar_ready path.
module ibex_axi_rd_mux #(
    parameter int  NUM_MST   = 2,
    parameter int  ID_W      = 1,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  MAX_OUTST = 4,
    localparam int IDX_W     = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    localparam int ARP_W     = ID_W + ADDR_W + 13,
    localparam int RP_W      = ID_W + DATA_W + 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_MST-1:0]       s_ar_valid,
    output logic [NUM_MST-1:0]       s_ar_ready,
    input  logic [NUM_MST*ARP_W-1:0] s_ar_pld,
    output logic [NUM_MST-1:0]       s_r_valid,
    input  logic [NUM_MST-1:0]       s_r_ready,
    output logic [RP_W-1:0]          s_r_pld,
    output logic                     m_ar_valid,
    input  logic                     m_ar_ready,
    output logic [IDX_W+ARP_W-1:0]   m_ar_pld,
    input  logic                     m_r_valid,
    output logic                     m_r_ready,
    input  logic [IDX_W+RP_W-1:0]    m_r_pld,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [NUM_MST-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]              rr_q, rr_d;
    logic                          err_q, err_d;

    logic [NUM_MST-1:0] elig;
    logic               arb_vld;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   grant;
    logic [ARP_W-1:0]   grant_pld;
    logic               ar_rdy;      // request of 'grant' is accepted this cycle

    logic [IDX_W-1:0]   r_idx;
    logic               r_known;
    logic [NUM_MST-1:0] inc, dec;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Outputs are forced idle while reset is asserted.
    always_comb begin
        for (int k = 0; k < NUM_MST; k++) begin
            elig[k] = !rst_i && s_ar_valid[k] && (cnt_q[k] < CNT_W'(MAX_OUTST));
        end
    end

    // Lowest eligible index overall covers the wrap-around case; the lowest
    // eligible index at or above rr overrides it when one exists.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (elig[k]) begin
                arb_vld = 1'b1;
                arb_idx = IDX_W'(k);
            end
        end
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (elig[k] && (IDX_W'(k) >= rr_q)) arb_idx = IDX_W'(k);
        end
    end

    always_comb begin
        grant_pld = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (grant == IDX_W'(k)) grant_pld = s_ar_pld[k*ARP_W +: ARP_W];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_MST; k++) begin
            s_ar_ready[k] = ar_rdy && (grant == IDX_W'(k));
        end
    end

`ifdef IBEX_AXI_RD_MUX_AR_REG_EN
    // Two entries let a push and a pop overlap every cycle, so the upstream
    // side never needs to look at m_ar_ready.
    logic [1:0][IDX_W+ARP_W-1:0] buf_q;
    logic                        wr_q, rd_q;
    logic [1:0]                  fill_q;
    logic                        pop;

    assign grant      = arb_idx;
    assign ar_rdy     = arb_vld && (fill_q != 2'd2);
    assign m_ar_valid = !rst_i && (fill_q != 2'd0);
    assign m_ar_pld   = buf_q[rd_q];
    assign pop        = m_ar_valid && m_ar_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            if (ar_rdy) begin
                buf_q[wr_q] <= {grant, grant_pld};
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            fill_q <= fill_q + 2'(ar_rdy) - 2'(pop);
        end
    end
`else
    // Once a request is presented downstream it must stay put until taken,
    // so the grant is frozen while m_ar_ready is low.
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;

    assign grant      = lock_q ? lock_idx_q : arb_idx;
    assign m_ar_valid = (lock_q && !rst_i) || arb_vld;
    assign m_ar_pld   = {grant, grant_pld};
    assign ar_rdy     = m_ar_valid && m_ar_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= m_ar_valid && !m_ar_ready;
            lock_idx_q <= grant;
        end
    end
`endif

    // ------------------------------------------------------------------
    // R routing
    // ------------------------------------------------------------------
    assign r_idx   = m_r_pld[IDX_W+RP_W-1 -: IDX_W];
    assign s_r_pld = m_r_pld[RP_W-1:0];

    // Beats for an index with no master are sunk (ready=1) and flagged.
    always_comb begin
        s_r_valid = '0;
        m_r_ready = 1'b1;
        r_known   = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (r_idx == IDX_W'(k)) begin
                s_r_valid[k] = m_r_valid && !rst_i;
                m_r_ready    = s_r_ready[k];
                r_known      = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-burst accounting
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_MST; k++) begin
            inc[k] = ar_rdy && (grant == IDX_W'(k));
            dec[k] = m_r_valid && m_r_ready && m_r_pld[0] && (r_idx == IDX_W'(k));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        rr_d  = rr_q;
        err_d = err_q || (m_r_valid && !r_known);
        for (int k = 0; k < NUM_MST; k++) begin
            if (inc[k] && !dec[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (dec[k] && !inc[k]) begin
                if (cnt_q[k] == '0) err_d = 1'b1;
                else                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
        end
        if (ar_rdy) rr_d = (grant == IDX_W'(NUM_MST - 1)) ? '0 : grant + IDX_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_ibex_axi_rd_mux.sv
// Bench for ibex_axi_rd_mux with NUM_MST=3, MAX_OUTST=2, narrow payloads.
// A table of per-cycle vectors runs the arbitration trace; short hand-written
// sequences cover grant hold, R backpressure within a burst, unknown-index
// beats and completions arriving after a reset.
module tb_ibex_axi_rd_mux;

    localparam int NM   = 3;
    localparam int IDW  = 1;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int MO   = 2;
    localparam int IDXW = 2;
    localparam int ARPW = IDW + AW + 13;
    localparam int RPW  = IDW + DW + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NM-1:0]        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [NM*ARPW-1:0]   s_ar_pld;
    logic [RPW-1:0]       s_r_pld;
    logic                 m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, err;
    logic [IDXW+ARPW-1:0] m_ar_pld;
    logic [IDXW+RPW-1:0]  m_r_pld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_axi_rd_mux #(
        .NUM_MST(NM), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_pld(s_ar_pld),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_pld(s_r_pld),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_pld(m_ar_pld),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_pld(m_r_pld),
        .err_o(err)
    );

    // Upstream AR payload of master k: {id, addr, len, size, burst}
    function automatic logic [ARPW-1:0] arp(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk[0], 8'(16 * (k + 1)), 8'd3, 3'd2, 2'd1};
    endfunction

    function automatic logic [IDXW+RPW-1:0] rpld(input logic [1:0] idx, input logic [7:0] d,
                                                 input logic last);
        return {idx, 1'b0, d, 2'b00, last};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        s_ar_valid = '0; m_ar_ready = 1'b0; m_r_valid = 1'b0;
        m_r_pld = '0; s_r_ready = '0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] arv;
        logic       arr;
        logic       rv;
        logic [1:0] ridx;
        logic       rl;
        logic [2:0] srr;
        logic       mav;
        logic [2:0] sar;
        logic [1:0] midx;
        logic [2:0] srv;
        logic       mrr;
        logic       err;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic [2:0] arv, input logic arr, input logic rv,
        input logic [1:0] ridx, input logic rl, input logic [2:0] srr,
        input logic mav, input logic [2:0] sar, input logic [1:0] midx,
        input logic [2:0] srv, input logic mrr, input logic e);
        vec_t v;
        v.rst = r; v.arv = arv; v.arr = arr; v.rv = rv; v.ridx = ridx; v.rl = rl;
        v.srr = srr; v.mav = mav; v.sar = sar; v.midx = midx; v.srv = srv;
        v.mrr = mrr; v.err = e;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        for (int k = 0; k < NM; k++) s_ar_pld[k*ARPW +: ARPW] = arp(k);

        //             rst arv    arr rv ridx rl srr   | mav sar    midx srv    mrr err
        tbl[0]  = mk(1, 3'b000, 0, 0, 2'd0, 0, 3'b000, 0, 3'b000, 2'd0, 3'b000, 0, 0);
        // three masters: 0,1,2,0
        tbl[1]  = mk(0, 3'b111, 1, 0, 2'd0, 0, 3'b000, 1, 3'b001, 2'd0, 3'b000, 0, 0);
        tbl[2]  = mk(0, 3'b111, 1, 0, 2'd0, 0, 3'b000, 1, 3'b010, 2'd1, 3'b000, 0, 0);
        tbl[3]  = mk(0, 3'b111, 1, 0, 2'd0, 0, 3'b000, 1, 3'b100, 2'd2, 3'b000, 0, 0);
        tbl[4]  = mk(0, 3'b111, 1, 0, 2'd0, 0, 3'b000, 1, 3'b001, 2'd0, 3'b000, 0, 0);
        tbl[5]  = mk(1, 3'b000, 0, 0, 2'd0, 0, 3'b000, 0, 3'b000, 2'd0, 3'b000, 0, 0);
        // two masters: 0,1,0,1 then both at MAX_OUTST
        tbl[6]  = mk(0, 3'b011, 1, 0, 2'd0, 0, 3'b000, 1, 3'b001, 2'd0, 3'b000, 0, 0);
        tbl[7]  = mk(0, 3'b011, 1, 0, 2'd0, 0, 3'b000, 1, 3'b010, 2'd1, 3'b000, 0, 0);
        tbl[8]  = mk(0, 3'b011, 1, 0, 2'd0, 0, 3'b000, 1, 3'b001, 2'd0, 3'b000, 0, 0);
        tbl[9]  = mk(0, 3'b011, 1, 0, 2'd0, 0, 3'b000, 1, 3'b010, 2'd1, 3'b000, 0, 0);
        // R last for master 1 frees one slot; master 0 stays blocked
        tbl[10] = mk(0, 3'b011, 1, 1, 2'd1, 1, 3'b010, 0, 3'b000, 2'd0, 3'b010, 1, 0);
        tbl[11] = mk(0, 3'b011, 1, 0, 2'd0, 0, 3'b000, 1, 3'b010, 2'd1, 3'b000, 0, 0);
        // R last for master 0 unblocks it on the next cycle
        tbl[12] = mk(0, 3'b011, 1, 1, 2'd0, 1, 3'b001, 0, 3'b000, 2'd0, 3'b001, 1, 0);
        tbl[13] = mk(0, 3'b011, 1, 0, 2'd0, 0, 3'b000, 1, 3'b001, 2'd0, 3'b000, 0, 0);

        rst = 1'b1;
        s_ar_valid = '0; m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_pld = '0; s_r_ready = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            rst        = tbl[i].rst;
            s_ar_valid = tbl[i].arv;
            m_ar_ready = tbl[i].arr;
            m_r_valid  = tbl[i].rv;
            m_r_pld    = rpld(tbl[i].ridx, 8'(i), tbl[i].rl);
            s_r_ready  = tbl[i].srr;
            @(negedge clk);
            chk($sformatf("v%0d m_ar_valid", i), m_ar_valid, tbl[i].mav);
            chk($sformatf("v%0d s_ar_ready", i), s_ar_ready, tbl[i].sar);
            if (tbl[i].mav)
                chk($sformatf("v%0d m_ar_pld", i), m_ar_pld, {tbl[i].midx, arp(int'(tbl[i].midx))});
            chk($sformatf("v%0d s_r_valid", i), s_r_valid, tbl[i].srv);
            chk($sformatf("v%0d m_r_ready", i), m_r_ready, tbl[i].mrr);
            chk($sformatf("v%0d err", i), err, tbl[i].err);
            if (tbl[i].rv)
                chk($sformatf("v%0d s_r_pld", i), s_r_pld, {1'b0, 8'(i), 2'b00, tbl[i].rl});
            tick();
        end

        // Grant hold: master 1 presented with m_ar_ready low, master 0 joins
        reset_dut();
        s_ar_valid = 3'b010;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) s_ar_valid = 3'b011;
            @(negedge clk);
            chk($sformatf("hold%0d m_ar_valid", c), m_ar_valid, 1'b1);
            chk($sformatf("hold%0d m_ar_pld", c), m_ar_pld, {2'd1, arp(1)});
            chk($sformatf("hold%0d s_ar_ready", c), s_ar_ready, 3'b000);
            tick();
        end
        m_ar_ready = 1'b1;
        @(negedge clk);
        chk("hold hs s_ar_ready", s_ar_ready, 3'b010);
        tick();
        s_ar_valid = 3'b001;
        @(negedge clk);
        chk("hold next s_ar_ready", s_ar_ready, 3'b001);
        chk("hold next m_ar_pld", m_ar_pld, {2'd0, arp(0)});
        tick();

        // R burst to master 1 with a stall on beat 2; master 1 at MAX_OUTST
        reset_dut();
        s_ar_valid = 3'b010; m_ar_ready = 1'b1;
        tick();
        tick();
        m_ar_ready = 1'b0;
        m_r_valid = 1'b1;
        s_r_ready = 3'b010;
        for (int b = 0; b < 5; b++) begin
            // b: beat1, beat2 stalled, beat2, beat3, beat4(last)
            m_r_pld   = rpld(2'd1, 8'hA0 + 8'(b), (b == 4));
            s_r_ready = (b == 1) ? 3'b000 : 3'b010;
            @(negedge clk);
            chk($sformatf("burst%0d s_r_valid", b), s_r_valid, 3'b010);
            chk($sformatf("burst%0d m_r_ready", b), m_r_ready, (b != 1));
            chk($sformatf("burst%0d m_ar_valid", b), m_ar_valid, 1'b0);
            chk($sformatf("burst%0d s_r_pld", b), s_r_pld, {1'b0, 8'hA0 + 8'(b), 2'b00, (b == 4)});
            tick();
        end
        m_r_valid = 1'b0; s_r_ready = '0;
        @(negedge clk);
        chk("burst done m_ar_valid", m_ar_valid, 1'b1);
        chk("burst done m_ar_pld", m_ar_pld, {2'd1, arp(1)});
        chk("burst done err", err, 1'b0);
        tick();

        // Beat for idx 3 (no such master): sunk and flagged until reset
        reset_dut();
        m_r_valid = 1'b1; m_r_pld = rpld(2'd3, 8'h33, 1'b1); s_r_ready = 3'b000;
        @(negedge clk);
        chk("bad idx m_r_ready", m_r_ready, 1'b1);
        chk("bad idx s_r_valid", s_r_valid, 3'b000);
        chk("bad idx err before edge", err, 1'b0);
        tick();
        m_r_valid = 1'b0; m_r_pld = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("bad idx err sticky", err, 1'b1);
        tick();
        reset_dut();
        @(negedge clk);
        chk("err cleared by reset", err, 1'b0);
        tick();

        // Late completion after reset: still delivered, flagged as underflow
        m_r_valid = 1'b1; m_r_pld = rpld(2'd0, 8'h5A, 1'b1); s_r_ready = 3'b001;
        @(negedge clk);
        chk("late beat s_r_valid", s_r_valid, 3'b001);
        chk("late beat m_r_ready", m_r_ready, 1'b1);
        tick();
        m_r_valid = 1'b0; s_r_ready = '0;
        @(negedge clk);
        chk("underflow err", err, 1'b1);
        tick();
        reset_dut();
        @(negedge clk);
        chk("underflow err cleared", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
